// File: rtl/uart_cmd_parser.sv
// UART command-frame parser: SOF, ADDR, DATA, CHK(=ADDR^DATA) -> one register-write command.
// Optional saturating error counter port err_count is built when UART_CMD_ERR_CNT_EN is defined.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_SOF  | hunting for the start-of-frame byte, junk dropped silently
// S_ADDR | waiting for the address byte
// S_DATA | waiting for the data byte
// S_CHK  | waiting for the checksum byte
// S_OUT  | command presented, receiver back-pressured until handshake
module uart_cmd_parser #(
   parameter logic [7:0]  SOF_BYTE    = 8'hA5,
   parameter int unsigned TIMEOUT_CYC = 416640
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_data_valid,
   output logic        rx_data_ready,
   output logic        cmd_valid,
   output logic [7:0]  cmd_addr,
   output logic [7:0]  cmd_data,
   input  logic        cmd_ready,
   output logic        frame_err,
`ifdef UART_CMD_ERR_CNT_EN
   output logic [15:0] err_count,
`endif
   output logic        timeout_err
);

   typedef enum logic [2:0] {S_SOF, S_ADDR, S_DATA, S_CHK, S_OUT} state_t;

   localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CYC - 1);

   state_t      state;
   logic [23:0] to_cnt;
   logic [7:0]  addr_q;
   logic [7:0]  data_q;
   logic        rx_acc;

   assign rx_data_ready = (state != S_OUT);
   assign rx_acc        = rx_data_valid && rx_data_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_SOF;
         to_cnt      <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         cmd_valid   <= 1'b0;
         cmd_addr    <= '0;
         cmd_data    <= '0;
         frame_err   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         frame_err   <= 1'b0;
         timeout_err <= 1'b0;
         case (state)
            S_SOF: begin
               to_cnt <= '0;
               if (rx_acc && rx_data == SOF_BYTE)
                  state <= S_ADDR;
            end
            S_ADDR, S_DATA, S_CHK: begin
               // an accepted byte wins over a timeout landing on the same edge
               if (rx_acc) begin
                  to_cnt <= '0;
                  if (state == S_ADDR) begin
                     addr_q <= rx_data;
                     state  <= S_DATA;
                  end else if (state == S_DATA) begin
                     data_q <= rx_data;
                     state  <= S_CHK;
                  end else if (rx_data == (addr_q ^ data_q)) begin
                     cmd_addr  <= addr_q;
                     cmd_data  <= data_q;
                     cmd_valid <= 1'b1;
                     state     <= S_OUT;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= S_SOF;
                  end
               end else if (to_cnt == TO_LAST) begin
                  to_cnt      <= '0;
                  timeout_err <= 1'b1;
                  state       <= S_SOF;
               end else begin
                  to_cnt <= to_cnt + 24'd1;
               end
            end
            S_OUT: begin
               to_cnt <= '0;
               if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  state     <= S_SOF;
               end
            end
            default: state <= S_SOF;
         endcase
      end
   end

`ifdef UART_CMD_ERR_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_count <= '0;
      else if ((frame_err || timeout_err) && err_count != 16'hFFFF)
         err_count <= err_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: directed frames push expected commands,
// a negedge monitor pops and compares on each command handshake.
module tb_uart_cmd_parser;
   localparam int TO = 50;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_data_valid = 1'b0;
   logic        rx_data_ready;
   logic        cmd_valid;
   logic [7:0]  cmd_addr;
   logic [7:0]  cmd_data;
   logic        cmd_ready = 1'b1;
   logic        frame_err;
   logic        timeout_err;
`ifdef UART_CMD_ERR_CNT_EN
   logic [15:0] err_count;
`endif

   always #5 clk = ~clk;

   uart_cmd_parser #(.SOF_BYTE(8'hA5), .TIMEOUT_CYC(TO)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .rx_data(rx_data),
      .rx_data_valid(rx_data_valid),
      .rx_data_ready(rx_data_ready),
      .cmd_valid(cmd_valid),
      .cmd_addr(cmd_addr),
      .cmd_data(cmd_data),
      .cmd_ready(cmd_ready),
      .frame_err(frame_err),
`ifdef UART_CMD_ERR_CNT_EN
      .err_count(err_count),
`endif
      .timeout_err(timeout_err)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] sb[$];
   int exp_cmd = 0, got_cmd = 0;
   int exp_ferr = 0, got_ferr = 0;
   int exp_terr = 0, got_terr = 0;
   logic prev_ferr = 1'b0, prev_terr = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s", name);
   endtask

   task automatic expect_cmd(input logic [7:0] a, input logic [7:0] d);
      sb.push_back({a, d});
      exp_cmd++;
   endtask

   // monitor: compares presented command against scoreboard head, pops on handshake
   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_err) begin
            got_ferr++;
            check("err_overlap", timeout_err, 0);
            check("ferr_width", prev_ferr, 0);
         end
         if (timeout_err) begin
            got_terr++;
            check("terr_width", prev_terr, 0);
         end
         if (cmd_valid) begin
            if (sb.size() == 0) fail("cmd_unexpected");
            else begin
               check("cmd_addr_data", {cmd_addr, cmd_data}, sb[0]);
               if (cmd_ready) begin
                  void'(sb.pop_front());
                  got_cmd++;
               end
            end
         end
      end
      prev_ferr = frame_err;
      prev_terr = timeout_err;
   end

   task automatic send_byte(input logic [7:0] b);
      bit acc = 1'b0;
      rx_data       = b;
      rx_data_valid = 1'b1;
      for (int i = 0; i < 400 && !acc; i++) begin
         @(negedge clk);
         acc = rx_data_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) fail("rx_accept_timeout");
   endtask

   task automatic send_seq(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
      send_byte(b0);
      send_byte(b1);
      send_byte(b2);
      send_byte(b3);
      rx_data_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      rx_data_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_cmd_valid", cmd_valid, 0);
      check("rst_rx_ready", rx_data_ready, 1);
      check("rst_cmd_addr_data", {cmd_addr, cmd_data}, 16'h0000);
      check("rst_errs", {frame_err, timeout_err}, 0);
      if (sb.size() != 0) begin
         exp_cmd -= sb.size();
         sb.delete();
      end
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_cmds"}, got_cmd, exp_cmd);
      check({tag, "_frame_err"}, got_ferr, exp_ferr);
      check({tag, "_timeout_err"}, got_terr, exp_terr);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit early;
      do_reset();

      // 1: good frame, latency and one-cycle pulse with cmd_ready=1
      expect_cmd(8'h12, 8'h34);
      send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34); send_byte(8'h26);
      rx_data_valid = 1'b0;
      check("t1_latency_valid", cmd_valid, 1);
      idle(1);
      check("t1_valid_dropped", cmd_valid, 0);
      idle(3);
      check_counts("t1");

      // 2: bad checksum then good frame
      send_seq(8'hA5, 8'h12, 8'h34, 8'h00);
      exp_ferr++;
      idle(3);
      check("t2_no_cmd", cmd_valid, 0);
      expect_cmd(8'h01, 8'h02);
      send_seq(8'hA5, 8'h01, 8'h02, 8'h03);
      idle(3);
      check_counts("t2");

      // 3: junk before SOF is dropped silently
      expect_cmd(8'h10, 8'h20);
      send_byte(8'h00); send_byte(8'hFF);
      send_seq(8'hA5, 8'h10, 8'h20, 8'h30);
      idle(3);
      check_counts("t3");

      // 4: timeout exactly TO cycles after the last byte, later bytes produce nothing
      send_byte(8'hA5); send_byte(8'h10);
      rx_data_valid = 1'b0;
      early = 1'b0;
      for (int i = 1; i < TO; i++) begin
         @(posedge clk); #1;
         if (timeout_err) early = 1'b1;
      end
      check("t4_no_early_timeout", early, 0);
      @(posedge clk); #1;
      check("t4_timeout_edge", timeout_err, 1);
      exp_terr++;
      idle(10);
      send_byte(8'h20); send_byte(8'h30);
      idle(3);
      check("t4_no_cmd", cmd_valid, 0);
      check_counts("t4");

      // 4b: byte accepted on the would-be timeout edge wins
      expect_cmd(8'h40, 8'h50);
      send_byte(8'hA5); send_byte(8'h40);
      idle(TO - 1);
      send_byte(8'h50); send_byte(8'h10);
      idle(3);
      check_counts("t4b");

      // 5: sink stalls for 100 cycles, receiver back-pressured
      cmd_ready = 1'b0;
      expect_cmd(8'h55, 8'h66);
      send_seq(8'hA5, 8'h55, 8'h66, 8'h33);
      idle(100);
      check("t5_valid_held", cmd_valid, 1);
      check("t5_rx_ready_low", rx_data_ready, 0);
      rx_data = 8'hA5; rx_data_valid = 1'b1;
      repeat (5) begin @(posedge clk); #1; end
      check("t5_byte_not_taken", {cmd_valid, rx_data_ready}, 2'b10);
      cmd_ready = 1'b1;
      send_byte(8'hA5);
      expect_cmd(8'h05, 8'h06);
      send_byte(8'h05); send_byte(8'h06); send_byte(8'h03);
      idle(3);
      check_counts("t5");

      // reset while a command is pending, then mid-frame
      cmd_ready = 1'b0;
      expect_cmd(8'h77, 8'h88);
      send_seq(8'hA5, 8'h77, 8'h88, 8'hFF);
      idle(3);
      do_reset();
      cmd_ready = 1'b1;
      send_byte(8'hA5); send_byte(8'h11);
      rx_data_valid = 1'b0;
      do_reset();
      send_byte(8'h22); send_byte(8'h33);
      expect_cmd(8'h07, 8'h08);
      send_seq(8'hA5, 8'h07, 8'h08, 8'h0F);
      idle(3);
      check_counts("t_rst");

`ifdef UART_CMD_ERR_CNT_EN
      // 6: error counter
      do_reset();
      check("t6_cnt_reset", err_count, 0);
      for (int k = 0; k < 3; k++) begin
         send_seq(8'hA5, 8'h01, 8'h02, 8'h00);
         exp_ferr++;
      end
      send_byte(8'hA5); send_byte(8'h01);
      idle(TO + 10);
      exp_terr++;
      idle(3);
      check("t6_cnt_four", err_count, 4);
      send_byte(8'hA5); send_byte(8'h01);
      rx_data_valid = 1'b0;
      do_reset();
      check("t6_cnt_cleared", err_count, 0);
      check_counts("t6");
`endif

      check("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
